// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_state_e    : transmitter FSM state encoding
//   UART_IDLE_LEVEL : line level while no frame is on the wire (mark)
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_ctr.sv
// Bit-period counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and wraps; tick_o marks the last cycle of a bit.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   clr_i  : restart the bit period (counter back to 0 on the next edge)
//   tick_o : high while the counter sits on its last value
module uart_baud_ctr #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one word per frame from the TX FIFO and serialises it
// as start bit, WIDTH data bits LSB first, then STOP_BITS stop bits.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset; drops any in-flight word
//   enable_i     : allows a new frame to start (looked at only while idle)
//   fifo_empty_i : FIFO empty flag (looked at only while idle)
//   fifo_pop_o   : one-cycle pop pulse, one per frame
//   fifo_data_i  : FIFO read data, valid the cycle after the pop
//   tx_o         : serial line, idles high
//   busy_o       : high from the pop cycle through the last stop-bit cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  uart_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             tx_q, tx_d;
  logic             pop_q, pop_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic             baud_clr;

  // Every state change restarts the bit period.
  assign baud_clr = (state_d != state_q);

  uart_baud_ctr #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  // State register (plus datapath and registered outputs).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      pop_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      pop_q      <= pop_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      StIdle: begin
        if (enable_i && !fifo_empty_i) begin
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StLoad;
      end
      StLoad: begin
        shift_d = fifo_data_i;
        state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IdxW'(WIDTH - 1)) begin
            stop_cnt_d = 1'b0;
            state_d    = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered copies line
  // up with the state they belong to.
  always_comb begin
    tx_d   = UART_IDLE_LEVEL;
    pop_d  = 1'b0;
    busy_d = 1'b1;
    case (state_d)
      StIdle:  busy_d = 1'b0;
      StPop:   pop_d  = 1'b1;
      StStart: tx_d   = ~UART_IDLE_LEVEL;
      StData:  tx_d   = shift_d[0];
      default: ;
    endcase
  end

  assign tx_o       = tx_q;
  assign fifo_pop_o = pop_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that drains bytes from a `fifo` instance through that FIFO's pop port and shifts them onto a single TX line. Framing is 8N1 by default, with configurable word width, stop bits and baud divisor. It is the read-side partner of the CPU-facing TX FIFO: software pushes, `uart_tx` pops. It sits in the peripheral subsystem next to the FIFO and drives the pad directly.

## Interface
- `WIDTH`, 8: data bits per frame; `fifo` instance uses the same `WIDTH`
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2
- `STOP_BITS`, 1: number of stop bits, 1 or 2
- `clk_i` in 1: single clock, all state on rising edge
- `rst_i` in 1: reset, synchronous and active-high
- `enable_i` in 1: permits starting new frames; sampled only in IDLE
- `fifo_empty_i` in 1: FIFO `empty_o`
- `fifo_pop_o` out 1: FIFO `pop_i`; single-cycle pulse per word
- `fifo_data_i` in WIDTH: FIFO `pop_data_o`; valid the cycle after `fifo_pop_o` is high
- `tx_o` out 1: serial line, idle high
- `busy_o` out 1: high from POP through the last stop-bit cycle

## Operation
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: `tx_o`=1. If `enable_i` && !`fifo_empty_i`, go to POP.
- POP: `fifo_pop_o`=1 for this cycle only, then go to LOAD.
- LOAD: capture `fifo_data_i` into the shift register, then go to START.
- START: `tx_o`=0 for `CLKS_PER_BIT` cycles.
- DATA: send `WIDTH` bits LSB first, each held `CLKS_PER_BIT` cycles. Shift right after each bit.
- STOP: `tx_o`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`, counts 0..`CLKS_PER_BIT`-1 and wraps. It is cleared on every state entry.
- Bit index: width `$clog2(WIDTH)`. Stop counter: 1 bit.
- `fifo_pop_o` never asserts while `fifo_empty_i`=1 and never outside POP. One pop per frame, no exceptions.
- `enable_i` deasserted mid-frame does not abort: the current frame completes and no new frame starts.
- `fifo_empty_i` is only examined in IDLE. Pushes arriving mid-frame are picked up at the next IDLE.
- Reset (`rst_i`=1 at an edge), at any point: next state IDLE, `tx_o`=1, `fifo_pop_o`=0, `busy_o`=0, counters 0. An in-flight word is dropped and never re-popped.
- Registered outputs. Reset values: `tx_o`=1, `fifo_pop_o`=0, `busy_o`=0.

## Timing
- Empty→non-empty with `enable_i`=1 seen in IDLE at edge N:
  - `fifo_pop_o` high in cycle N+1.
  - LOAD in cycle N+2.
  - First start-bit cycle on `tx_o` is N+3.
- Frame length: (1 + `WIDTH` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, from the first start cycle to the last stop cycle.
- Back-to-back words: exactly 3 cycles with `tx_o`=1 between the last stop cycle and the next start (IDLE, POP, LOAD).
- `busy_o` drops in the IDLE cycle between frames, even when the FIFO is non-empty.
- `fifo_data_i` is sampled only in LOAD.

## Structure
- `uart_pkg`:
  - `uart_state_e` enum (IDLE, POP, LOAD, START, DATA, STOP)
  - `UART_IDLE_LEVEL`=1'b1
- Sub-module `uart_baud_ctr`:
  - Parameterised by `CLKS_PER_BIT`.
  - Inputs `clr_i`; outputs `tick_o` (high on the last cycle of a bit).
  - Reused by the future `uart_rx`.
- FSM and shift register stay in `uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `WIDTH`=8, and a real `fifo` #(8,16) instance.
- Reset with FIFO empty, `enable_i`=1 for 50 cycles → `tx_o`=1, `fifo_pop_o`=0, `busy_o`=0 throughout.
- Push 0xA5 → one `fifo_pop_o` pulse, then `tx_o`: 0×4, then bits 1,0,1,0,0,1,0,1 each ×4, then 1×4. Total 40 cycles; `fifo_empty_i` returns to 1.
- Push 0x00 and 0xFF on consecutive cycles → exactly two pops and two frames, with exactly 3 high cycles between the first stop and the second start. Then IDLE.
- `enable_i`=0 with 0x3C queued for 100 cycles → no pop, `tx_o`=1. Raise `enable_i` → frame for 0x3C. Drop `enable_i` at data bit 2 → frame still completes.
- Assert `rst_i` for one cycle during data bit 4 of 0x81 while 0x42 is queued → `tx_o`=1 on the next cycle and `busy_o`=0. The next frame carries 0x42; 0x81 is never retransmitted.
- `STOP_BITS`=2, push 0x55 → stop phase is 8 high cycles; frame is 44 cycles.
